// File: rtl/pipe_skid_reg.sv
// Purpose : registered pipeline stage with a one-entry skid buffer and a saturating stall counter.
// Latency : one cycle from accept to out_*; in_ready comes straight from a flop, so it never depends combinationally on out_ready.
// Backpressure: a second entry parks in skid while main is stalled; in_ready drops only when skid is occupied.
//
// Ports:
//   clk, reset (async active-low), flush (sync kill of held entries)
//   in_valid/in_ready/in_ctrl/in_data    upstream handshake + payload
//   out_valid/out_ready/out_ctrl/out_data downstream handshake + payload (driven from main)
//   stall_cnt                            saturating count of out_valid & !out_ready cycles
module pipe_skid_reg #(
  parameter int                 DATA_W   = 8,
  parameter int                 CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{1'b0}},
  parameter int                 CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              r_main_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_vld;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_accept;
  logic w_release;
  logic w_stall;

  // skid can only be occupied while main is occupied, so in_ready low
  // always implies a full stage.
  assign w_accept  = in_valid & ~r_skid_vld;
  assign w_release = r_main_vld & out_ready;
  assign w_stall   = r_main_vld & ~out_ready;

  assign in_ready  = ~r_skid_vld;
  assign out_valid = r_main_vld;
  assign out_ctrl  = r_main_ctrl;
  assign out_data  = r_main_data;
  assign stall_cnt = r_stall_cnt;

  // Entry storage. out_ctrl is forced to the bubble code whenever main
  // empties so downstream sees a harmless control word; out_data is left
  // alone in that case to avoid needless toggling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_vld  <= 1'b0;
      r_main_ctrl <= CTRL_RST;
      r_main_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      // flush beats any simultaneous accept/release; the incoming entry is lost
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main_ctrl <= CTRL_RST;
    end else if (w_release) begin
      if (r_skid_vld) begin
        // in_ready is low here, so no accept can coincide with the drain
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
        r_skid_vld  <= 1'b0;
      end else if (w_accept) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else begin
        r_main_vld  <= 1'b0;
        r_main_ctrl <= CTRL_RST;
      end
    end else if (w_accept) begin
      if (!r_main_vld) begin
        r_main_vld  <= 1'b1;
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else begin
        r_skid_vld  <= 1'b1;
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  // Stall counter ignores flush: it measures downstream backpressure seen
  // on the wire, not what happens to the entries afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

endmodule
